// File: rtl/int_ack_sequencer.sv
// int_ack_sequencer: CPU-side 8259 INTA sequencer (sync INT, two INTA pulses, vector capture, valid/ready handoff)
module int_ack_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PULSE_CYCLES   = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int RECOVER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       int_req,
  input  logic       int_enable,
  input  logic [7:0] data_bus,
  input  logic       vector_ready,
  output logic       int_ack,
  output logic       busy,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       vector_spurious,
  output logic [7:0] ack_count
);
  localparam int MAX_PG = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int MAXC = (MAX_PG > RECOVER_CYCLES) ? MAX_PG : RECOVER_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] R_LAST = CW'(RECOVER_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, ACK1, GAP, ACK2, DONE, RECOVER} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic int_req_s;
  assign int_req_s = sync[SYNC_STAGES-1];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      sync            <= '0;
      int_ack         <= 1'b0;
      busy            <= 1'b0;
      vector          <= 8'h00;
      vector_valid    <= 1'b0;
      vector_spurious <= 1'b0;
      ack_count       <= 8'h00;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], int_req};
      case (state)
        IDLE: if (int_req_s && int_enable) begin
          state   <= ACK1;
          cnt     <= '0;
          int_ack <= 1'b1;
          busy    <= 1'b1;
        end
        ACK1: if (cnt == P_LAST) begin
          state   <= GAP;
          cnt     <= '0;
          int_ack <= 1'b0;
        end else cnt <= cnt + 1'b1;
        // spurious flag reflects INT as seen at the instant the vector pulse begins
        GAP: if (cnt == G_LAST) begin
          state           <= ACK2;
          cnt             <= '0;
          int_ack         <= 1'b1;
          vector_spurious <= ~int_req_s;
        end else cnt <= cnt + 1'b1;
        ACK2: if (cnt == P_LAST) begin
          state        <= DONE;
          cnt          <= '0;
          int_ack      <= 1'b0;
          vector       <= data_bus;
          vector_valid <= 1'b1;
        end else cnt <= cnt + 1'b1;
        DONE: if (vector_ready) begin
          state        <= RECOVER;
          cnt          <= '0;
          vector_valid <= 1'b0;
          ack_count    <= ack_count + 8'd1;
        end
        RECOVER: if (cnt == R_LAST) begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end else cnt <= cnt + 1'b1;
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          int_ack <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_int_ack_sequencer.sv
// tb_int_ack_sequencer: directed bench with a timeline model of the INTA protocol checked every cycle
module tb_int_ack_sequencer;
  localparam int S = 2, P = 2, G = 2, R = 4, L = 2 * P + G;
  logic clk = 1'b0, reset = 1'b1, int_req = 1'b0, int_enable = 1'b1, vector_ready = 1'b0;
  logic [7:0] data_bus = 8'h48;
  logic int_ack, busy, vector_valid, vector_spurious;
  logic [7:0] vector, ack_count;
  int total = 0, passed = 0;

  int_ack_sequencer dut (
    .clk(clk), .reset(reset), .int_req(int_req), .int_enable(int_enable),
    .data_bus(data_bus), .vector_ready(vector_ready), .int_ack(int_ack), .busy(busy),
    .vector(vector), .vector_valid(vector_valid), .vector_spurious(vector_spurious),
    .ack_count(ack_count)
  );

  always #5 clk = ~clk;

  // t = clocks since the first INTA pulse began (-1 when idle); outputs follow from windows on t
  int t = -1;
  logic [S-1:0] h = '0;
  logic [7:0] m_vec = 8'h00, m_cnt = 8'h00;
  logic m_sp = 1'b0, req_s;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t = -1; h = '0; m_vec = 8'h00; m_cnt = 8'h00; m_sp = 1'b0;
    end else begin
      req_s = h[S-1];
      if (t < 0) begin
        if (req_s && int_enable) t = 0;
      end else if (t < L) begin
        if (t == P + G - 1) m_sp = !req_s;
        if (t == L - 1) m_vec = data_bus;
        t++;
      end else if (t == L) begin
        if (vector_ready) begin m_cnt = m_cnt + 8'd1; t++; end
      end else if (t < L + R) t++;
      else t = -1;
      h = {h[S-2:0], int_req};
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("m_int_ack", int'(int_ack), int'(t >= 0 && (t < P || (t >= P + G && t < L))));
    chk("m_busy", int'(busy), int'(t >= 0));
    chk("m_valid", int'(vector_valid), int'(t == L));
    chk("m_vector", int'(vector), int'(m_vec));
    chk("m_spurious", int'(vector_spurious), int'(m_sp));
    chk("m_ack_count", int'(ack_count), int'(m_cnt));
  end

  task automatic wait_sig(input int which, input logic lvl, input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = ((which == 0) ? int_ack : (which == 1) ? vector_valid : busy) == lvl;
    end
    chk(nm, int'(ok), 1);
  endtask

  task automatic finish_seq();
    vector_ready = 1'b1;
    int_req = 1'b0;
    wait_sig(2, 1'b0, "wait_idle");
    vector_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [8:0] pat;
    int seen, errs, n, nseq, cyc, low_run, bad;
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({int_ack, busy, vector_valid, vector_spurious, vector, ack_count}), 0);
    reset = 1'b0;
    @(negedge clk);
    // 1: default sequence, INTA pattern and vector capture
    int_req = 1'b1;
    pat = '0;
    for (int i = 0; i < 9; i++) begin @(negedge clk); pat = {pat[7:0], int_ack}; end
    chk("t1_inta_pattern", int'(pat), int'(9'b001100110));
    chk("t1_vector", int'(vector), 8'h48);
    chk("t1_valid", int'(vector_valid), 1);
    vector_ready = 1'b1;
    int_req = 1'b0;
    @(negedge clk);
    chk("t1_ack_count", int'(ack_count), 1);
    finish_seq();
    // 2: disabled interrupts hold off, enabling starts within one clock
    int_enable = 1'b0;
    int_req = 1'b1;
    seen = 0;
    repeat (50) begin @(negedge clk); seen += int'(int_ack | busy); end
    chk("t2_disabled_quiet", seen, 0);
    int_enable = 1'b1;
    @(negedge clk);
    chk("t2_enable_start", int'(int_ack), 1);
    finish_seq();
    // 3: INT withdrawn before the vector pulse gives a spurious vector
    data_bus = 8'h4F;
    int_req = 1'b1;
    wait_sig(0, 1'b1, "t3_wait_ack1");
    int_req = 1'b0;
    wait_sig(1, 1'b1, "t3_wait_valid");
    chk("t3_vector", int'(vector), 8'h4F);
    chk("t3_spurious", int'(vector_spurious), 1);
    finish_seq();
    // 4: CPU stalls in DONE
    data_bus = 8'h21;
    int_req = 1'b1;
    wait_sig(1, 1'b1, "t4_wait_valid");
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      errs += int'(!vector_valid || vector != 8'h21 || int_ack);
    end
    chk("t4_stall_hold", errs, 0);
    chk("t4_not_spurious", int'(vector_spurious), 0);
    finish_seq();
    // 5: reset in the vector pulse, then a fresh sequence
    data_bus = 8'h33;
    int_req = 1'b1;
    wait_sig(0, 1'b1, "t5_wait_ack1");
    wait_sig(0, 1'b0, "t5_wait_gap");
    wait_sig(0, 1'b1, "t5_wait_ack2");
    #2 reset = 1'b1;
    #1 chk("t5_async_clear", int'({int_ack, vector_valid, busy, ack_count}), 0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && !int_ack; i++) begin @(negedge clk); n++; end
    chk("t5_restart_latency", n, S + 1);
    wait_sig(1, 1'b1, "t5_wait_valid");
    chk("t5_vector", int'(vector), 8'h33);
    finish_seq();
    chk("t5_ack_count", int'(ack_count), 1);
    // 6: 256 back-to-back handshakes wrap the counter
    vector_ready = 1'b1;
    int_req = 1'b1;
    nseq = 0; cyc = 0; low_run = 0; bad = 0;
    while (nseq < 256 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (vector_valid) nseq++;
      if (int_ack) begin
        if (low_run > 0 && low_run != G && low_run < R + 1) bad++;
        low_run = 0;
      end else low_run++;
    end
    chk("t6_sequences", nseq, 256);
    chk("t6_low_gaps", bad, 0);
    finish_seq();
    chk("t6_wrap", int'(ack_count), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
